bsram_port_arbiter: RTL and testbench
=====================================

Name: bsram_port_arbiter

Overview:
- Dynamic arbiter that shares one single-port BSRAM (e.g. the FFT0 working RAM) among three requesters: 0 = demodulation sequencer, 1 = FFT engine, 2 = OFDM symbol decoder.
- Replaces the static select-driven port mux. Each requester uses a req/grant handshake; ownership is held for a whole burst.
- Before ownership changes, the block drains in-flight reads so read data is always tagged to the requester that issued the read.
- Sits between the requester engines and the BSRAM primitive.

Parameters:
- AW, 11, BSRAM address width
- DW, 32, BSRAM data width
- READ_LATENCY, 2, cycles from a read command (ce=1, wre=0) to valid dout; legal values 1 or 2

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  3  per-requester access request; bit i belongs to requester i
- grant  out  3  one-hot ownership, registered
- ce_i  in  3  per-requester clock enable
- oce_i  in  3  per-requester output clock enable
- wre_i  in  3  per-requester write enable
- ad_i  in  3*AW  per-requester address; slice [i*AW +: AW]
- din_i  in  3*DW  per-requester write data; slice [i*DW +: DW]
- ram_ce  out  1  to BSRAM
- ram_oce  out  1  to BSRAM
- ram_wre  out  1  to BSRAM
- ram_ad  out  AW  to BSRAM
- ram_din  out  DW  to BSRAM
- ram_dout  in  DW  from BSRAM
- rdata  out  DW  ram_dout passed straight through
- rvalid  out  3  one-hot; bit i marks rdata as valid for requester i
- busy  out  1  high in GRANT or DRAIN

Behaviour:
- Reset values:
  - grant=0, rvalid=0, busy=0.
  - All ram_* outputs = 0.
  - State = IDLE, drain counter = 0, read pipeline cleared, last_owner = 2 (so requester 0 has first priority).
- FSM states: IDLE, GRANT, DRAIN.
- IDLE:
  - If any req bit is set, pick a winner round-robin, searching from last_owner+1 mod 3.
  - At the next edge: grant goes one-hot to the winner, last_owner is updated, state goes to GRANT.
  - Grant latency is 1 cycle after req is sampled high.
- GRANT:
  - Port mux is combinational from the owner index: ram_ce = ce_i[o] & req[o]; ram_wre = wre_i[o] & req[o]; ram_oce = oce_i[o]; ram_ad and ram_din come from owner o's slices.
  - When req[o] is sampled low: next edge clears grant and enters DRAIN with counter = READ_LATENCY.
  - A requester must hold req high through its last command cycle. Commands issued while req is low are blocked (ram_ce=0).
- DRAIN:
  - ram_ce=0, ram_wre=0, ram_ad=0, ram_din=0.
  - ram_oce stays driven by the previous owner so pipelined output registers can update.
  - Counter decrements each cycle; at 0 the FSM goes to IDLE.
  - IDLE then arbitrates in the same cycle, so the new grant appears on the next edge.
  - Minimum owner-to-owner gap = READ_LATENCY+1 cycles with grant=0.
- Outside GRANT/DRAIN, all ram_* outputs = 0.
- Read tracking:
  - A read is issued when ram_ce=1 and ram_wre=0. It pushes a one-hot owner tag into a READ_LATENCY-deep shift register.
  - rvalid is the shift-register output, so it asserts exactly READ_LATENCY cycles after the read command.
  - Writes (ram_wre=1) never produce rvalid.
  - Back-to-back reads give back-to-back rvalid pulses.
- Boundary conditions:
  - Simultaneous requests: round-robin order only; no starvation. Each requester waits at most 2 bursts.
  - The owner dropping req while others request still goes through DRAIN.
  - The owner re-asserting req during DRAIN competes normally and gets lowest priority (it is last_owner).
  - req glitches on non-owners have no effect in GRANT.
  - Async rst mid-burst: all outputs return to reset values immediately. In-flight rvalid pulses are discarded.
  - The grant vector is never multi-hot; the verification bench asserts $onehot0(grant) every cycle.

Test Plan:
- Single requester: req[1]=1 at cycle 0 -> grant=3'b010 at cycle 1. Reads to ad 5,6,7 in cycles 1-3 -> rvalid=3'b010 in cycles 3,4,5 (READ_LATENCY=2) with rdata = RAM[5],RAM[6],RAM[7].
- Contention after reset: req=3'b111 at cycle 0 -> grant order 0,1,2. Each owner holds 4 cycles; the gap between grants is 3 cycles with grant=0.
- Write then read by different owners: requester 0 writes 0xDEADBEEF to ad 0x10 and releases; requester 2 reads ad 0x10 -> rvalid=3'b100 with rdata=0xDEADBEEF. No rvalid ever reaches bit 0.
- Drain integrity: requester 1 issues a read on its last req-high cycle while requester 2 is waiting -> rvalid=3'b010 arrives during DRAIN, and grant[2] rises only after the drain completes.
- Blocked access: ungranted requester drives ce_i[2]=1, wre_i[2]=1 during requester 0's burst -> the ram_* outputs carry requester 0's signals only, and RAM contents at requester 2's address are unchanged.
- Reset mid-burst: rst pulsed while grant=3'b001 with 2 reads in flight -> grant=0, rvalid=0, ram_ce=0 during reset. After reset, req[0]=1 is granted in 1 cycle with no stale rvalid.

Source files
------------

// File: rtl/bsram_port_arbiter.sv
// Round-robin req/grant arbiter sharing one single-port BSRAM among three engines.
// Ownership is held per burst and in-flight reads drain before ownership moves on.
module bsram_port_arbiter #(
  parameter int unsigned AW           = 11,
  parameter int unsigned DW           = 32,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req,
  output logic [2:0]        grant,
  input  logic [2:0]        ce_i,
  input  logic [2:0]        oce_i,
  input  logic [2:0]        wre_i,
  input  logic [3*AW-1:0]   ad_i,
  input  logic [3*DW-1:0]   din_i,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic [AW-1:0]     ram_ad,
  output logic [DW-1:0]     ram_din,
  input  logic [DW-1:0]     ram_dout,
  output logic [DW-1:0]     rdata,
  output logic [2:0]        rvalid,
  output logic              busy
);

  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN} state_t;

  state_t          r_state;
  logic [1:0]      r_owner;
  logic [1:0]      r_last;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_grant;
  logic            r_busy;
  logic [2:0]      r_pipe [READ_LATENCY];

  logic            w_ce;
  logic            w_oce;
  logic            w_wre;
  logic            w_req;
  logic [AW-1:0]   w_ad;
  logic [DW-1:0]   w_din;
  logic            w_rd;
  logic [1:0]      w_win;

  // Winner is the first requester found searching upward from last+1 (mod 3).
  function automatic logic [1:0] f_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] w_c;
    f_pick = last;
    for (int k = 3; k >= 1; k--) begin
      w_c = 2'((int'(last) + k) % 3);
      if (r[w_c]) f_pick = w_c;
    end
  endfunction

  assign w_win  = f_pick(req, r_last);
  assign grant  = r_grant;
  assign busy   = r_busy;
  assign rvalid = r_pipe[READ_LATENCY-1];
  assign rdata  = ram_dout;
  assign w_rd   = ram_ce & ~ram_wre;

  always_comb begin
    w_ce  = 1'b0;
    w_oce = 1'b0;
    w_wre = 1'b0;
    w_req = 1'b0;
    w_ad  = '0;
    w_din = '0;
    case (r_owner)
      2'd0: begin
        w_ce = ce_i[0]; w_oce = oce_i[0]; w_wre = wre_i[0]; w_req = req[0];
        w_ad = ad_i[0 +: AW]; w_din = din_i[0 +: DW];
      end
      2'd1: begin
        w_ce = ce_i[1]; w_oce = oce_i[1]; w_wre = wre_i[1]; w_req = req[1];
        w_ad = ad_i[AW +: AW]; w_din = din_i[DW +: DW];
      end
      2'd2: begin
        w_ce = ce_i[2]; w_oce = oce_i[2]; w_wre = wre_i[2]; w_req = req[2];
        w_ad = ad_i[2*AW +: AW]; w_din = din_i[2*DW +: DW];
      end
      default: ;
    endcase
  end

  // Owner drives the RAM only while it holds req; DRAIN keeps only oce alive.
  always_comb begin
    ram_ce  = 1'b0;
    ram_oce = 1'b0;
    ram_wre = 1'b0;
    ram_ad  = '0;
    ram_din = '0;
    if (r_state == S_GRANT) begin
      ram_ce  = w_ce & w_req;
      ram_wre = w_wre & w_req;
      ram_oce = w_oce;
      ram_ad  = w_ad;
      ram_din = w_din;
    end else if (r_state == S_DRAIN) begin
      ram_oce = w_oce;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= 2'd0;
      r_last  <= 2'd2;
      r_cnt   <= '0;
      r_grant <= 3'b000;
      r_busy  <= 1'b0;
      for (int i = 0; i < int'(READ_LATENCY); i++) r_pipe[i] <= 3'b000;
    end else begin
      r_pipe[0] <= w_rd ? r_grant : 3'b000;
      for (int i = 1; i < int'(READ_LATENCY); i++) r_pipe[i] <= r_pipe[i-1];
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_grant <= 3'b001 << w_win;
            r_owner <= w_win;
            r_last  <= w_win;
            r_busy  <= 1'b1;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (!w_req) begin
            r_grant <= 3'b000;
            r_cnt   <= CW'(READ_LATENCY);
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_cnt <= r_cnt - CW'(1);
          // Leave on the edge where the counter reaches zero so IDLE can arbitrate at once.
          if (r_cnt <= CW'(1)) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsram_port_arbiter.sv
// Directed bench for bsram_port_arbiter with a behavioural two-stage BSRAM model.
module tb_bsram_port_arbiter;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;

  logic            clk;
  logic            rst;
  logic [2:0]      req, grant, ce_i, oce_i, wre_i, rvalid;
  logic [3*AW-1:0] ad_i;
  logic [3*DW-1:0] din_i;
  logic            ram_ce, ram_oce, ram_wre, busy;
  logic [AW-1:0]   ram_ad;
  logic [DW-1:0]   ram_din, ram_dout, rdata;

  int checks = 0;
  int errors = 0;

  bsram_port_arbiter #(.AW(AW), .DW(DW), .READ_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant),
    .ce_i(ce_i), .oce_i(oce_i), .wre_i(wre_i), .ad_i(ad_i), .din_i(din_i),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre), .ram_ad(ram_ad),
    .ram_din(ram_din), .ram_dout(ram_dout), .rdata(rdata), .rvalid(rvalid),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BSRAM model: address register stage then output register stage (latency 2).
  logic [DW-1:0] mem [2048];
  logic [DW-1:0] s1;
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'hA500_0000 | 32'(i);
    s1 = '0;
    ram_dout = '0;
  end
  always @(posedge clk) begin
    if (ram_ce && ram_wre) mem[ram_ad] <= ram_din;
    if (ram_ce && !ram_wre) s1 <= mem[ram_ad];
    if (ram_oce) ram_dout <= s1;
  end

  always @(negedge clk) begin
    checks++;
    if (!$onehot0(grant)) begin
      errors++;
      $display("FAIL onehot0: grant=%b", grant);
    end
  end

  typedef struct {
    logic [2:0]    req, ce, wre;
    logic [AW-1:0] a0, a1, a2;
    logic [31:0]   din, din2;
    logic [2:0]    e_grant, e_rvalid;
    logic          e_ce, e_wre;
    logic [AW-1:0] e_ad;
    logic [31:0]   e_din, e_rdata;
    logic          e_busy;
  } vec_t;

  vec_t vt [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req = 3'b000; ce_i = 3'b000; wre_i = 3'b000; oce_i = 3'b111;
    ad_i = '0; din_i = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    req = v.req; ce_i = v.ce; wre_i = v.wre; oce_i = 3'b111;
    ad_i = {v.a2, v.a1, v.a0};
    din_i = {v.din2, v.din, v.din};
  endtask

  initial begin
    int held [3];
    logic [2:0] g;
    logic [2:0] exp_g;

    rst = 1'b1;
    idle_inputs();
    // req ce wre | a0 a1 a2 | din din2 | grant rvalid ce wre ad din rdata busy
    vt[0]  = '{3'b010, 3'b000, 3'b000, 11'h0,   11'h5, 11'h0,   32'h0,        32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 11'h0,   32'h0,        32'h0,        1'b0};
    vt[1]  = '{3'b010, 3'b010, 3'b000, 11'h0,   11'h5, 11'h0,   32'h0,        32'h0,        3'b010, 3'b000, 1'b1, 1'b0, 11'h5,   32'h0,        32'h0,        1'b1};
    vt[2]  = '{3'b010, 3'b010, 3'b000, 11'h0,   11'h6, 11'h0,   32'h0,        32'h0,        3'b010, 3'b000, 1'b1, 1'b0, 11'h6,   32'h0,        32'h0,        1'b1};
    vt[3]  = '{3'b010, 3'b010, 3'b000, 11'h0,   11'h7, 11'h0,   32'h0,        32'h0,        3'b010, 3'b010, 1'b1, 1'b0, 11'h7,   32'h0,        32'hA5000005, 1'b1};
    vt[4]  = '{3'b000, 3'b000, 3'b000, 11'h0,   11'h0, 11'h0,   32'h0,        32'h0,        3'b010, 3'b010, 1'b0, 1'b0, 11'h0,   32'h0,        32'hA5000006, 1'b1};
    vt[5]  = '{3'b000, 3'b000, 3'b000, 11'h0,   11'h0, 11'h0,   32'h0,        32'h0,        3'b000, 3'b010, 1'b0, 1'b0, 11'h0,   32'h0,        32'hA5000007, 1'b1};
    vt[6]  = '{3'b000, 3'b000, 3'b000, 11'h0,   11'h0, 11'h0,   32'h0,        32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 11'h0,   32'h0,        32'h0,        1'b1};
    vt[7]  = '{3'b001, 3'b000, 3'b000, 11'h0,   11'h0, 11'h0,   32'h0,        32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 11'h0,   32'h0,        32'h0,        1'b0};
    vt[8]  = '{3'b101, 3'b101, 3'b101, 11'h010, 11'h0, 11'h210, 32'hDEADBEEF, 32'h12345678, 3'b001, 3'b000, 1'b1, 1'b1, 11'h010, 32'hDEADBEEF, 32'h0,        1'b1};
    vt[9]  = '{3'b101, 3'b000, 3'b100, 11'h0,   11'h0, 11'h210, 32'h0,        32'h12345678, 3'b001, 3'b000, 1'b0, 1'b0, 11'h0,   32'h0,        32'h0,        1'b1};
    vt[10] = '{3'b100, 3'b100, 3'b100, 11'h0,   11'h0, 11'h210, 32'h0,        32'h12345678, 3'b001, 3'b000, 1'b0, 1'b0, 11'h0,   32'h0,        32'h0,        1'b1};
    vt[11] = '{3'b100, 3'b000, 3'b000, 11'h0,   11'h0, 11'h0,   32'h0,        32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 11'h0,   32'h0,        32'h0,        1'b1};
    vt[12] = '{3'b100, 3'b000, 3'b000, 11'h0,   11'h0, 11'h0,   32'h0,        32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 11'h0,   32'h0,        32'h0,        1'b1};
    vt[13] = '{3'b100, 3'b000, 3'b000, 11'h0,   11'h0, 11'h0,   32'h0,        32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 11'h0,   32'h0,        32'h0,        1'b0};
    vt[14] = '{3'b100, 3'b100, 3'b000, 11'h0,   11'h0, 11'h010, 32'h0,        32'h0,        3'b100, 3'b000, 1'b1, 1'b0, 11'h010, 32'h0,        32'h0,        1'b1};
    vt[15] = '{3'b100, 3'b100, 3'b000, 11'h0,   11'h0, 11'h210, 32'h0,        32'h0,        3'b100, 3'b000, 1'b1, 1'b0, 11'h210, 32'h0,        32'h0,        1'b1};
    vt[16] = '{3'b100, 3'b000, 3'b000, 11'h0,   11'h0, 11'h0,   32'h0,        32'h0,        3'b100, 3'b100, 1'b0, 1'b0, 11'h0,   32'h0,        32'hDEADBEEF, 1'b1};
    vt[17] = '{3'b000, 3'b000, 3'b000, 11'h0,   11'h0, 11'h0,   32'h0,        32'h0,        3'b100, 3'b100, 1'b0, 1'b0, 11'h0,   32'h0,        32'hA5000210, 1'b1};
    vt[18] = '{3'b000, 3'b000, 3'b000, 11'h0,   11'h0, 11'h0,   32'h0,        32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 11'h0,   32'h0,        32'h0,        1'b1};
    vt[19] = '{3'b000, 3'b000, 3'b000, 11'h0,   11'h0, 11'h0,   32'h0,        32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 11'h0,   32'h0,        32'h0,        1'b1};
    vt[20] = '{3'b000, 3'b000, 3'b000, 11'h0,   11'h0, 11'h0,   32'h0,        32'h0,        3'b000, 3'b000, 1'b0, 1'b0, 11'h0,   32'h0,        32'h0,        1'b0};

    do_reset();
    chk("reset grant", 32'(grant), 32'h0);
    chk("reset rvalid", 32'(rvalid), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset ram_ce", 32'({ram_ce, ram_oce, ram_wre}), 32'h0);

    // Single requester reads, then write by 0 / read by 2 with blocked access by 2.
    for (int k = 0; k < 21; k++) begin
      apply(vt[k]);
      #1;
      chk($sformatf("vec%0d grant", k), 32'(grant), 32'(vt[k].e_grant));
      chk($sformatf("vec%0d rvalid", k), 32'(rvalid), 32'(vt[k].e_rvalid));
      chk($sformatf("vec%0d ram_ce", k), 32'(ram_ce), 32'(vt[k].e_ce));
      chk($sformatf("vec%0d ram_wre", k), 32'(ram_wre), 32'(vt[k].e_wre));
      chk($sformatf("vec%0d ram_ad", k), 32'(ram_ad), 32'(vt[k].e_ad));
      chk($sformatf("vec%0d ram_din", k), ram_din, vt[k].e_din);
      chk($sformatf("vec%0d busy", k), 32'(busy), 32'(vt[k].e_busy));
      if (vt[k].e_rvalid != 3'b000)
        chk($sformatf("vec%0d rdata", k), rdata, vt[k].e_rdata);
      next_cycle();
    end

    // Contention: all three request, each holds grant 4 cycles, 3-cycle gaps.
    do_reset();
    for (int i = 0; i < 3; i++) held[i] = 0;
    for (int c = 0; c < 23; c++) begin
      g = grant;
      for (int i = 0; i < 3; i++) begin
        if (g[i]) held[i]++;
        req[i] = (held[i] < 4);
      end
      exp_g = 3'b000;
      for (int k = 0; k < 3; k++)
        if (c >= 1 + 7*k && c <= 4 + 7*k) exp_g = 3'b001 << k;
      #1;
      chk($sformatf("rr c%0d grant", c), 32'(grant), 32'(exp_g));
      next_cycle();
    end

    // Drain integrity and lowest priority for the owner re-requesting during DRAIN.
    do_reset();
    req = 3'b010; #1;
    chk("drain c0 grant", 32'(grant), 32'h0);
    next_cycle();
    req = 3'b110; ce_i = 3'b010; ad_i = {11'h0, 11'h033, 11'h0}; #1;
    chk("drain c1 grant", 32'(grant), 32'h2);
    chk("drain c1 ram_ce", 32'(ram_ce), 32'h1);
    next_cycle();
    req = 3'b100; ce_i = 3'b000; ad_i = '0; #1;
    chk("drain c2 grant", 32'(grant), 32'h2);
    chk("drain c2 ram_ce", 32'(ram_ce), 32'h0);
    next_cycle();
    #1;
    chk("drain c3 grant", 32'(grant), 32'h0);
    chk("drain c3 rvalid", 32'(rvalid), 32'h2);
    chk("drain c3 rdata", rdata, 32'hA5000033);
    chk("drain c3 ram_oce", 32'(ram_oce), 32'h1);
    next_cycle();
    req = 3'b110; #1;
    chk("drain c4 grant", 32'(grant), 32'h0);
    chk("drain c4 rvalid", 32'(rvalid), 32'h0);
    next_cycle();
    #1;
    chk("drain c5 grant", 32'(grant), 32'h0);
    chk("drain c5 busy", 32'(busy), 32'h0);
    next_cycle();
    #1;
    chk("drain c6 grant", 32'(grant), 32'h4);
    idle_inputs();
    next_cycle();

    // Asynchronous reset while requester 0 has two reads in flight.
    do_reset();
    req = 3'b001; #1;
    chk("rst c0 grant", 32'(grant), 32'h0);
    next_cycle();
    ce_i = 3'b001; ad_i = {11'h0, 11'h0, 11'h020}; #1;
    chk("rst c1 grant", 32'(grant), 32'h1);
    next_cycle();
    ad_i = {11'h0, 11'h0, 11'h021}; #1;
    chk("rst c2 ram_ce", 32'(ram_ce), 32'h1);
    rst = 1'b1; #1;
    chk("rst async grant", 32'(grant), 32'h0);
    chk("rst async rvalid", 32'(rvalid), 32'h0);
    chk("rst async ram_ce", 32'(ram_ce), 32'h0);
    chk("rst async busy", 32'(busy), 32'h0);
    idle_inputs();
    next_cycle();
    #1;
    chk("rst c3 rvalid", 32'(rvalid), 32'h0);
    rst = 1'b0;
    next_cycle();
    req = 3'b001; #1;
    chk("rst c4 rvalid", 32'(rvalid), 32'h0);
    chk("rst c4 grant", 32'(grant), 32'h0);
    next_cycle();
    #1;
    chk("rst c5 grant", 32'(grant), 32'h1);
    chk("rst c5 rvalid", 32'(rvalid), 32'h0);
    next_cycle();
    #1;
    chk("rst c6 rvalid", 32'(rvalid), 32'h0);
    idle_inputs();
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
